// File: rtl/mem_access.sv
// Memory stage: issues data-memory requests for loads/stores and passes other results through.
// Every accepted instruction yields exactly one registered writeback beat.
module mem_access #(
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter logic [6:0]  OP_LOAD     = 7'b0000011,
  parameter logic [6:0]  OP_STORE    = 7'b0100011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        wb_reg,
  input  logic [4:0]  rd_num,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd_num,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (BUS_TIMEOUT > 0) ? CNT_W'(BUS_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_p0;
  logic [1:0]        off_p0;
  logic              is_load_p0;
  logic              wb_reg_p0;
  logic [4:0]        rd_p0;

  logic              in_is_load, in_is_store, in_mem, in_legal, in_mis, in_err, accept, timeout;
  logic              wb_fire, wb_en_nxt, mis_nxt, berr_nxt;
  logic [31:0]       wb_data_nxt;
  logic [4:0]        rd_nxt;
  logic signed [31:0] load_val;

  function automatic logic signed [31:0] load_extend(input logic [2:0] f3,
                                                     input logic [31:0] rdata,
                                                     input logic [1:0] off);
    logic [31:0]        lane;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] res;
    lane = rdata >> {off, 3'b000};
    sb   = lane[7:0];
    sh   = lane[15:0];
    case (f3)
      3'b000:  res = sb;
      3'b001:  res = sh;
      3'b100:  res = {24'b0, lane[7:0]};
      3'b101:  res = {16'b0, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign in_ready    = (state == IDLE);
  assign dmem_req    = (state == REQ);
  assign accept      = in_valid && in_ready;
  assign in_is_load  = (opcode == OP_LOAD);
  assign in_is_store = (opcode == OP_STORE);
  assign in_mem      = in_is_load || in_is_store;
  assign in_legal    = in_is_load ? (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                  : (func3 inside {3'b000, 3'b001, 3'b010});
  assign in_mis      = ((func3[1:0] == 2'b01) && alu_result[0]) ||
                       ((func3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
  assign in_err      = in_mem && (!in_legal || in_mis);
  assign timeout     = (BUS_TIMEOUT > 0) && (cnt == CNT_LAST);
  assign load_val    = load_extend(f3_p0, dmem_rdata, off_p0);

  // Next state and writeback values; completion is checked before timeout so it wins a tie.
  always_comb begin
    state_nxt   = state;
    wb_fire     = 1'b0;
    wb_en_nxt   = 1'b0;
    wb_data_nxt = '0;
    mis_nxt     = 1'b0;
    berr_nxt    = 1'b0;
    rd_nxt      = rd_p0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          rd_nxt = rd_num;
          if (in_mem && !in_err) begin
            state_nxt = REQ;
          end else begin
            state_nxt = RESP;
            wb_fire   = 1'b1;
            if (in_err) begin
              mis_nxt = 1'b1;
            end else begin
              wb_en_nxt   = wb_reg && (rd_num != 5'd0);
              wb_data_nxt = alu_result;
            end
          end
        end
      end
      REQ: begin
        if (dmem_gnt && !is_load_p0) begin
          state_nxt = RESP;
          wb_fire   = 1'b1;
        end else if (dmem_gnt && dmem_rvalid) begin
          state_nxt   = RESP;
          wb_fire     = 1'b1;
          wb_en_nxt   = wb_reg_p0 && (rd_p0 != 5'd0);
          wb_data_nxt = load_val;
        end else if (timeout) begin
          state_nxt = RESP;
          wb_fire   = 1'b1;
          berr_nxt  = 1'b1;
        end else if (dmem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_nxt   = RESP;
          wb_fire     = 1'b1;
          wb_en_nxt   = wb_reg_p0 && (rd_p0 != 5'd0);
          wb_data_nxt = load_val;
        end else if (timeout) begin
          state_nxt = RESP;
          wb_fire   = 1'b1;
          berr_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_en      <= 1'b0;
      wb_rd_num  <= '0;
      wb_data    <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt        <= '0;
        dmem_addr  <= {alu_result[31:2], 2'b00};
        dmem_we    <= in_is_store;
        dmem_wstrb <= in_is_store ? store_wstrb(func3, alu_result[1:0]) : 4'b0000;
        dmem_wdata <= in_is_store ? store_wdata(func3, store_data) : 32'd0;
      end else if ((BUS_TIMEOUT > 0) && ((state == REQ) || (state == WAIT))) begin
        cnt <= cnt + 1'b1;
      end
      wb_valid   <= wb_fire;
      wb_en      <= wb_fire && wb_en_nxt;
      misaligned <= wb_fire && mis_nxt;
      bus_err    <= wb_fire && berr_nxt;
      if (wb_fire) begin
        wb_rd_num <= rd_nxt;
        wb_data   <= wb_data_nxt;
      end
    end
  end

  // Instruction capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_p0      <= func3;
      off_p0     <= alu_result[1:0];
      is_load_p0 <= in_is_load;
      wb_reg_p0  <= wb_reg;
      rd_p0      <= rd_num;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table, hand-written reset/late-response sequences and random
// instructions compared against a byte-level behavioural model.
module tb_mem_access;
  localparam int T = 16;
  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        wb_reg = 1'b0;
  logic [4:0]  rd_num = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_en, misaligned, bus_err;
  logic [4:0]  wb_rd_num;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  mem_access #(.BUS_TIMEOUT(T), .OP_LOAD(OP_LD), .OP_STORE(OP_ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .alu_result(alu_result), .store_data(store_data),
    .wb_reg(wb_reg), .rd_num(rd_num), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd_num(wb_rd_num), .wb_data(wb_data),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        wbreg;
    logic [4:0]  rd;
    int          g;      // extra request cycles before gnt
    int          rv;     // cycles from gnt to rvalid; negative = never
    logic [31:0] rdata;
    logic        en;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        berr;
  } vec_t;

  typedef struct {
    int          lat;
    int          reqc;
    logic [31:0] baddr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        en;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        berr;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic wbreg, input logic [4:0] rd,
                              input int g, input int rv, input logic [31:0] rdata,
                              input logic en, input logic [31:0] data, input logic chk_data,
                              input logic mis, input logic berr);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.wbreg = wbreg; v.rd = rd;
    v.g = g; v.rv = rv; v.rdata = rdata; v.en = en; v.data = data; v.chk_data = chk_data;
    v.mis = mis; v.berr = berr;
    return v;
  endfunction

  // Behavioural model: bytes of the bus word are treated as an array indexed by address offset.
  function automatic exp_t model(input vec_t v);
    exp_t   e;
    int     size, off, n_done;
    bit     is_ld, is_st, legal;
    longint val;
    e = '{default: 0};
    is_ld = (v.op == OP_LD);
    is_st = (v.op == OP_ST);
    e.lat = 1;
    e.baddr = v.addr & 32'hFFFF_FFFC;
    e.we = is_st;
    case (v.f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      default: size = 4;
    endcase
    off = int'(v.addr[1:0]);
    legal = is_ld ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 <= 3'd2);
    if (!is_ld && !is_st) begin
      e.en = v.wbreg && (v.rd != 0);
      e.data = v.addr;
      e.chk_data = 1'b1;
    end else if (!legal || (off % size) != 0) begin
      e.mis = 1'b1;
    end else begin
      if (is_st)
        for (int i = 0; i < 4; i++) begin
          e.wstrb[i] = (i >= off) && (i < off + size);
          e.wdata[8*i +: 8] = v.sdata[8*(i % size) +: 8];
        end
      e.reqc = v.g + 1;
      n_done = v.g + 1 + (is_ld ? v.rv : 0);
      if ((is_ld && v.rv < 0) || n_done > T) begin
        e.berr = 1'b1;
        e.lat = T + 1;
        if (e.reqc > T) e.reqc = T;
      end else begin
        e.lat = n_done + 1;
        if (is_ld) begin
          val = 0;
          for (int i = 0; i < size; i++)
            val += longint'(v.rdata[8*(off+i) +: 8]) << (8*i);
          if (!v.f3[2] && size < 4 && val >= (longint'(1) << (8*size - 1)))
            val -= (longint'(1) << (8*size));
          e.data = val[31:0];
          e.en = v.wbreg && (v.rd != 0);
          e.chk_data = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic drive_instr(input vec_t v);
    opcode = v.op; func3 = v.f3; alu_result = v.addr; store_data = v.sdata;
    wb_reg = v.wbreg; rd_num = v.rd; dmem_rdata = v.rdata;
    in_valid = 1'b1;
  endtask

  // Issues one instruction, plays the memory side, and checks bus and writeback behaviour.
  task automatic run_instr(input string tag, input vec_t v, input exp_t e);
    int lat, reqc, c, gc;
    logic stable;
    logic [31:0] a0, wd0;
    logic [3:0] ws0;
    logic we0, ld;
    logic cen, cmis, cberr;
    logic [4:0] crd;
    logic [31:0] cdat;
    lat = 0; reqc = 0; c = 0; gc = -1; stable = 1'b1;
    a0 = '0; wd0 = '0; ws0 = '0; we0 = 1'b0;
    cen = 1'b0; cmis = 1'b0; cberr = 1'b0; crd = '0; cdat = '0;
    ld = (v.op == OP_LD);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    drive_instr(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (c < 60 && lat == 0) begin
      c++;
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (wb_valid) begin
        lat = c;
        cen = wb_en; cmis = misaligned; cberr = bus_err; crd = wb_rd_num; cdat = wb_data;
      end else begin
        if (dmem_req) begin
          reqc++;
          if (reqc == 1) begin
            a0 = dmem_addr; we0 = dmem_we; ws0 = dmem_wstrb; wd0 = dmem_wdata;
          end else if (dmem_addr !== a0 || dmem_we !== we0 || dmem_wstrb !== ws0 || dmem_wdata !== wd0) begin
            stable = 1'b0;
          end
          if (reqc - 1 == v.g) begin
            dmem_gnt = 1'b1;
            gc = c;
          end
        end
        if (ld && v.rv >= 0 && gc >= 0 && c == gc + v.rv) dmem_rvalid = 1'b1;
        @(posedge clk); #1;
      end
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_req_cycles"}, 32'(reqc), 32'(e.reqc));
    if (e.reqc > 0) begin
      check({tag, "_addr"}, a0, e.baddr);
      check({tag, "_we"}, 32'(we0), 32'(e.we));
      check({tag, "_wstrb"}, 32'(ws0), 32'(e.wstrb));
      check({tag, "_wdata"}, wd0, e.wdata);
      check({tag, "_bus_stable"}, 32'(stable), 32'd1);
    end
    if (lat != 0) begin
      check({tag, "_wb_en"}, 32'(cen), 32'(e.en));
      check({tag, "_misaligned"}, 32'(cmis), 32'(e.mis));
      check({tag, "_bus_err"}, 32'(cberr), 32'(e.berr));
      check({tag, "_wb_rd"}, 32'(crd), 32'(v.rd));
      if (e.chk_data) check({tag, "_wb_data"}, cdat, e.data);
      @(posedge clk); #1;
      check({tag, "_wb_pulse"}, 32'(wb_valid), 32'd0);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    exp_t e;
    e = model(v);
    e.en = v.en; e.data = v.data; e.chk_data = v.chk_data; e.mis = v.mis; e.berr = v.berr;
    run_instr(tag, v, e);
  endtask

  // Reset asserted while a load is outstanding (in REQ or in WAIT); later responses must be ignored.
  task automatic reset_mid(input string tag, input bit in_wait);
    vec_t v;
    v = mk(OP_LD, 3'd2, 32'h300, 0, 1, 1, 0, 0, 32'h1111_2222, 0, 0, 0, 0, 0);
    drive_instr(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_req_before"}, 32'(dmem_req), 32'd1);
    if (in_wait) begin
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      @(posedge clk); #1;
      check({tag, "_in_wait"}, 32'(in_ready), 32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    check({tag, "_wbv_low"}, 32'(wb_valid), 32'd0);
    check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_gnt = 1'b1;
    dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    check({tag, "_late_wbv"}, 32'(wb_valid), 32'd0);
    check({tag, "_late_req"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    vec_t tbl[18];
    vec_t v;
    tbl[0]  = mk(OP_ADD, 3'd0, 32'h0000_000B, 0, 1, 3, 0, 0, 0, 1, 32'h0000_000B, 1, 0, 0);
    tbl[1]  = mk(OP_ST, 3'd0, 32'h0000_0103, 32'h1234_5678, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(OP_LD, 3'd0, 32'h0000_0102, 0, 1, 5, 0, 3, 32'h0080_0000, 1, 32'hFFFF_FF80, 1, 0, 0);
    tbl[3]  = mk(OP_LD, 3'd4, 32'h0000_0102, 0, 1, 5, 0, 3, 32'h0080_0000, 1, 32'h0000_0080, 1, 0, 0);
    tbl[4]  = mk(OP_LD, 3'd5, 32'h0000_0102, 0, 1, 6, 1, 1, 32'h8001_0000, 1, 32'h0000_8001, 1, 0, 0);
    tbl[5]  = mk(OP_LD, 3'd2, 32'h0000_0106, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(OP_LD, 3'd3, 32'h0000_0100, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(OP_LD, 3'd2, 32'h0000_0104, 0, 1, 8, 1, -1, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(OP_LD, 3'd2, 32'h0000_0108, 0, 1, 9, 0, 15, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1, 0, 0);
    tbl[9]  = mk(OP_LD, 3'd2, 32'h0000_010C, 0, 1, 9, 15, 0, 32'h1357_9BDF, 1, 32'h1357_9BDF, 1, 0, 0);
    tbl[10] = mk(OP_LD, 3'd2, 32'h0000_0110, 0, 1, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1, 0, 0);
    tbl[11] = mk(OP_ST, 3'd1, 32'h0000_0102, 32'hAABB_CCDD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(OP_LD, 3'd1, 32'h0000_0100, 0, 1, 4, 0, 0, 32'h0000_8001, 1, 32'hFFFF_8001, 1, 0, 0);
    tbl[13] = mk(OP_ST, 3'd2, 32'h0000_0114, 32'h55AA_55AA, 0, 0, 20, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(OP_ST, 3'd3, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(OP_ST, 3'd2, 32'h0000_0101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[16] = mk(OP_ADD, 3'd0, 32'h0000_0077, 0, 1, 0, 0, 0, 0, 0, 32'h0000_0077, 1, 0, 0);
    tbl[17] = mk(OP_LD, 3'd1, 32'h0000_0101, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset state
    #12;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_rd", 32'(wb_rd_num), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_flags", {30'd0, misaligned, bus_err}, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Timeout abort followed by a late rvalid while idle
    v = mk(OP_LD, 3'd2, 32'h0000_0200, 0, 1, 11, 0, -1, 32'h7777_7777, 0, 0, 0, 0, 1);
    run_vec("late_to", v);
    dmem_rvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("late_rvalid%0d", k), 32'(wb_valid), 32'd0);
    end
    dmem_rvalid = 1'b0;

    reset_mid("rst_req", 1'b0);
    reset_mid("rst_wait", 1'b1);
    run_vec("post_rst_add", tbl[0]);
    run_vec("post_rst_rd0", tbl[10]);

    // Random instructions against the model
    for (int n = 0; n < 40; n++) begin
      exp_t e;
      int sel;
      sel = int'($urandom_range(0, 2));
      v.op    = (sel == 0) ? OP_LD : (sel == 1) ? OP_ST : OP_ADD;
      v.f3    = 3'($urandom_range(0, 5));
      v.addr  = $urandom;
      v.sdata = $urandom;
      v.wbreg = 1'($urandom_range(0, 1));
      v.rd    = 5'($urandom_range(0, 31));
      v.g     = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(0, 4));
      v.rv    = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      v.rdata = $urandom;
      e = model(v);
      run_instr($sformatf("rnd%0d", n), v, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
